// File: rtl/p_d_seq.sv
// ---------------------------------------------------------------------------
// p_d_seq : sequential 3-to-8 priority decoder with valid/ready input.
//
// It accepts one 3-bit index per transaction and drives the matching one-hot
// line on d_out for HOLD cycles. It then inserts GAP forced idle cycles. This
// is the receive-side partner of the 8-to-3 priority encoder: in_none marks
// the encoder's "no bit set" case, which shares code 000 and decodes to zero.
//
// Parameters
//   HOLD  cycles d_out stays asserted per transaction (1..255)
//   GAP   forced idle cycles after each transaction   (0..15)
//
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   in_valid  upstream index valid
//   in_ready  block can accept an index (0 in reset and while abort=1)
//   in_code   index to decode, 0..7
//   in_none   decode to all-zero instead of a one-hot line
//   abort     synchronous cancel of the current transaction
//   d_out     registered one-hot output (or zero)
//   busy      registered, high in DRIVE and GAP
//   done      one-cycle pulse on the last DRIVE cycle
//   err       sticky loopback mismatch flag
//
// Build option
//   P_D_LOOPBACK_EN  when defined, an internal 8-to-3 priority encoder
//                    re-encodes d_out during DRIVE and sets err on a mismatch
//                    with the latched code. When undefined, err is tied to 0.
// ---------------------------------------------------------------------------
module p_d_seq #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
  input  logic       in_none,
  input  logic       abort,
  output logic [7:0] d_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // The hold counter is loaded with HOLD-1. DRIVE therefore lasts exactly
  // HOLD cycles: it ends in the cycle where the counter reads zero.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
  // With GAP=0 the GAP state is never entered, so its load value is unused.
  localparam bit         HAS_GAP   = (GAP > 0);
  localparam logic [3:0] GAP_LOAD  = HAS_GAP ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e     state_q;
  logic [7:0] hold_cnt_q;
  logic [3:0] gap_cnt_q;
  logic [2:0] code_q;
  logic       none_q;
  logic [7:0] d_out_q;
  logic       busy_q;

  // One-hot decodes of the live input index and of the latched index.
  logic [7:0] onehot_in_d;
  logic [7:0] onehot_lat_d;
  logic [7:0] accept_pattern_d;
  logic [7:0] latched_pattern_d;
  logic       accept_d;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dec
      assign onehot_in_d[gi]  = (in_code == 3'(gi));
      assign onehot_lat_d[gi] = (code_q  == 3'(gi));
    end
  endgenerate

  assign accept_pattern_d  = in_none ? 8'h00 : onehot_in_d;
  assign latched_pattern_d = none_q  ? 8'h00 : onehot_lat_d;

  // Ready is decoded from the state. It is also gated by reset and abort,
  // so no index is taken while the block is held in reset or being
  // cancelled.
  assign in_ready = rst_n && !abort && (state_q == ST_IDLE);
  assign accept_d = in_valid && in_ready;

  // done is decoded from the state and the counter, with no input path.
  assign done  = (state_q == ST_DRIVE) && (hold_cnt_q == 8'd0);
  assign d_out = d_out_q;
  assign busy  = busy_q;

  // -------------------------------------------------------------------------
  // Sequencer: state, counters, latched index and registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= 8'd0;
      gap_cnt_q  <= 4'd0;
      code_q     <= 3'd0;
      none_q     <= 1'b0;
      d_out_q    <= 8'h00;
      busy_q     <= 1'b0;
    end else if (abort) begin
      // The cancel wins over every other transition. In IDLE, in_ready is
      // already 0, so nothing is accepted in the same cycle.
      state_q    <= ST_IDLE;
      hold_cnt_q <= 8'd0;
      gap_cnt_q  <= 4'd0;
      d_out_q    <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            code_q     <= in_code;
            none_q     <= in_none;
            hold_cnt_q <= HOLD_LOAD;
            // d_out is valid from the acceptance edge onward.
            d_out_q    <= accept_pattern_d;
            busy_q     <= 1'b1;
            state_q    <= ST_DRIVE;
          end
        end

        ST_DRIVE: begin
          if (hold_cnt_q != 8'd0) begin
            hold_cnt_q <= hold_cnt_q - 8'd1;
            // Each cycle, d_out is rebuilt from the latched index. A
            // disturbed output register then recovers on the next edge,
            // and the live in_code has no influence here.
            d_out_q    <= latched_pattern_d;
          end else begin
            d_out_q <= 8'h00;
            if (HAS_GAP) begin
              state_q   <= ST_GAP;
              gap_cnt_q <= GAP_LOAD;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt_q != 4'd0) begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          d_out_q <= 8'h00;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef P_D_LOOPBACK_EN
  // -------------------------------------------------------------------------
  // Loopback check: re-encode what is actually on d_out and compare it with
  // the index we meant to drive. Highest set bit wins; zero encodes to 000.
  // -------------------------------------------------------------------------
  function automatic logic [2:0] enc8(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  logic err_q;
  logic loop_mismatch_d;

  // A none transaction drives zero on purpose, so it is excluded from the
  // check: zero would re-encode to 000 whatever index was latched.
  assign loop_mismatch_d = (state_q == ST_DRIVE) && !none_q &&
                           (enc8(d_out_q) != code_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b0;
    end else if (loop_mismatch_d) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_p_d_seq.sv
// ---------------------------------------------------------------------------
// Bench for p_d_seq.
// Instance dut  : HOLD=4, GAP=1
// Instance dut0 : HOLD=4, GAP=0 (back-to-back acceptance)
//
// When the stimulus process sees a transaction accepted, it pushes the
// per-cycle expected response of that transaction into a queue. Separate
// monitor processes pop one entry on every busy cycle and compare it.
// ---------------------------------------------------------------------------
module tb_p_d_seq;

  typedef struct packed {
    logic [7:0] d;
    logic       dn;
  } exp_t;

  localparam int HOLD = 4;
  localparam int GAP  = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // dut (GAP=1)
  logic       in_valid, in_none, abort;
  logic [2:0] in_code;
  logic       in_ready, busy, done, err;
  logic [7:0] d_out;

  // dut0 (GAP=0)
  logic       v0, n0, abort0;
  logic [2:0] c0;
  logic       rdy0, busy0, done0, err0;
  logic [7:0] d0;

  exp_t q1[$];
  exp_t q0[$];

  int n_checks = 0;
  int n_err    = 0;
  bit skip_chk = 1'b0;

  always #5 clk = ~clk;

  p_d_seq #(.HOLD(HOLD), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_none(in_none), .abort(abort),
    .d_out(d_out), .busy(busy), .done(done), .err(err)
  );

  p_d_seq #(.HOLD(HOLD), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0),
    .in_code(c0), .in_none(n0), .abort(abort0),
    .d_out(d0), .busy(busy0), .done(done0), .err(err0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
    end
  endtask

  // Monitor for dut: one expected entry per busy cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !skip_chk) begin
      if (busy) begin
        if (q1.size() == 0) begin
          chk("unexpected_busy", 32'(busy), 32'd0);
        end else begin
          e = q1.pop_front();
          chk("d_out", 32'(d_out), 32'(e.d));
          chk("done", 32'(done), 32'(e.dn));
          $display("mon dut : d_out=%02h done=%0d", d_out, done);
        end
      end else begin
        chk("idle_d_out", 32'(d_out), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
      end
      chk("err", 32'(err), 32'd0);
    end
  end

  // Monitor for dut0.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (busy0) begin
        if (q0.size() == 0) begin
          chk("unexpected_busy0", 32'(busy0), 32'd0);
        end else begin
          e = q0.pop_front();
          chk("d_out0", 32'(d0), 32'(e.d));
          chk("done0", 32'(done0), 32'(e.dn));
          $display("mon dut0: d_out=%02h done=%0d", d0, done0);
        end
      end else begin
        chk("idle_d_out0", 32'(d0), 32'd0);
        chk("idle_done0", 32'(done0), 32'd0);
      end
      chk("err0", 32'(err0), 32'd0);
    end
  end

  task automatic push_exp(input logic [7:0] d, input int gap_cycles, input bit to_q0);
    exp_t e;
    for (int i = 0; i < HOLD; i++) begin
      e.d  = d;
      e.dn = (i == HOLD - 1);
      if (to_q0) q0.push_back(e); else q1.push_back(e);
    end
    for (int i = 0; i < gap_cycles; i++) begin
      e.d  = 8'h00;
      e.dn = 1'b0;
      if (to_q0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  // Offers one index to dut, pushes the expected response at the handshake,
  // and returns 1 ns after the acceptance edge.
  task automatic send(input logic [2:0] c, input logic nn, input logic [7:0] expd);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_code  = c;
    in_none  = nn;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) break;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      push_exp(expd, GAP, 1'b0);
      $display("send code=%0d none=%0d expect=%02h", c, nn, expd);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_code  = 3'($urandom);
    in_none  = 1'($urandom);
  endtask

  // Counts busy negedges until in_ready returns; exp_cycles<0 skips the
  // latency comparison but still flags a timeout.
  task automatic wait_ready(input int exp_cycles, input string nm);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) break;
    end
    if (!in_ready) chk({nm, "_timeout"}, 32'(in_ready), 32'd1);
    else if (exp_cycles >= 0) chk(nm, n, exp_cycles);
  endtask

  logic [7:0] exp_tab [8];

  initial begin
    int n;
    exp_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    abort0 = 1'b0;
    abort  = 1'b0;

    // ---- reset with random inputs ----
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); in_code = 3'($urandom); in_none = 1'($urandom);
      v0 = 1'($urandom); c0 = 3'($urandom); n0 = 1'($urandom);
      #2;
      chk("rst_d_out", 32'(d_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_in_ready0", 32'(rdy0), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; v0 = 1'b0; abort = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    $display("reset released");

    // ---- codes 0..7 with HOLD=4, GAP=1 ----
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 1'b0, exp_tab[i]);
      wait_ready(HOLD + GAP, "ready_latency");
    end

    // ---- in_none: zero output, still busy, single done ----
    send(3'd3, 1'b1, 8'h00);
    wait_ready(HOLD + GAP, "ready_latency_none");

    // ---- abort on the 2nd DRIVE cycle of code 7 ----
    send(3'd7, 1'b0, 8'h80);
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_in_ready_drive", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("abort_busy_cleared", 32'(busy), 32'd0);
    chk("abort_d_out_cleared", 32'(d_out), 32'd0);
    q1.delete();
    // abort still high in IDLE with a valid offer: nothing may be accepted
    in_valid = 1'b1; in_code = 3'd4; in_none = 1'b0;
    @(negedge clk);
    chk("abort_blocks_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_no_accept", 32'(busy), 32'd0);
    @(negedge clk);
    chk("ready_after_abort", 32'(in_ready), 32'd1);
    $display("abort sequence done");

    // ---- asynchronous reset mid-DRIVE ----
    send(3'd2, 1'b0, 8'h04);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_d_out", 32'(d_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    $display("mid-drive reset done");

    // ---- GAP=0 instance, in_valid held high: code 1 then code 6 ----
    @(posedge clk); #1;
    v0 = 1'b1; c0 = 3'd1; n0 = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (rdy0) break;
      n++;
      if (n > 300) break;
    end
    chk("gap0_first_ready", 32'(rdy0), 32'd1);
    push_exp(8'h02, 0, 1'b1);
    $display("send0 code=1 expect=02");
    @(posedge clk); #1;
    c0 = 3'd6;
    n = 0;
    forever begin
      @(negedge clk);
      if (rdy0) break;
      n++;
      if (n > 300) break;
    end
    chk("gap0_back_to_back", n, HOLD);
    push_exp(8'h40, 0, 1'b1);
    $display("send0 code=6 expect=40");
    @(posedge clk); #1;
    v0 = 1'b0;
    repeat (HOLD + 2) @(posedge clk);

`ifdef P_D_LOOPBACK_EN
    // ---- loopback fault: corrupt d_out during DRIVE ----
    skip_chk = 1'b1;
    send(3'd4, 1'b0, 8'h10);
    force dut.d_out_q = 8'h30;
    @(posedge clk); #1;
    chk("loop_err_set", 32'(err), 32'd1);
    release dut.d_out_q;
    wait_ready(-1, "loop_ready");
    chk("loop_err_sticky", 32'(err), 32'd1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("loop_err_cleared", 32'(err), 32'd0);
    q1.delete();
    skip_chk = 1'b0;
    $display("loopback fault sequence done");
`endif

    repeat (4) @(posedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q0_drained", q0.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/p_d_seq.md
# p_d_seq

Sequential 3-to-8 priority decoder with a valid/ready input handshake. It is the receive-side counterpart of the 8-to-3 priority encoder `p_e`. The block accepts one 3-bit index per transaction and drives the matching one-hot 8-bit line for a fixed number of cycles, then inserts an optional idle gap. It sits downstream of an encoded-index link and regenerates strobe lines for the consumer logic.

## Interface
- `HOLD`, default 4: cycles the one-hot output stays asserted per transaction; legal range 1..255.
- `GAP`, default 1: forced idle cycles after each transaction; legal range 0..15.
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: the upstream index is valid this cycle.
- `in_ready` output 1: the block can accept an index this cycle.
- `in_code` input 3: the index to decode, in the range 0..7.
- `in_none` input 1: when 1, the transaction drives all-zero. This covers the encoder's no-bit-set case, which shares code 000.
- `abort` input 1: synchronous cancel of the current transaction.
- `d_out` output 8: registered one-hot output, or all-zero.
- `busy` output 1: high in DRIVE and GAP.
- `done` output 1: one-cycle pulse on the last DRIVE cycle.
- `err` output 1: sticky loopback mismatch flag (see Configuration).

## Operation
- States:
  - IDLE: `in_ready`=1, `d_out`=0.
  - DRIVE: `d_out` = (`in_none` ? 0 : 1<<code).
  - GAP: `d_out`=0, `in_ready`=0.
- Acceptance: `in_valid`&&`in_ready` at a rising edge.
  - The block latches `in_code` and `in_none` into internal registers.
  - It loads the hold counter with HOLD-1 and moves IDLE→DRIVE.
- Inputs are ignored outside an acceptance edge. Changing `in_code` during DRIVE has no effect.
- DRIVE:
  - While the counter is nonzero, the counter decrements each cycle.
  - When the counter is 0, the block asserts `done` combinationally from state. At the next edge it goes to GAP (GAP>0, loading the gap counter with GAP-1) or to IDLE (GAP=0).
- GAP: the gap counter decrements each cycle. When it reaches 0, the next edge goes to IDLE.
- Counter widths: 8-bit hold counter, 4-bit gap counter. The counters never wrap, because transitions occur at 0.
- `abort` overrides everything and is checked at each edge:
  - In DRIVE or GAP, the next state is IDLE, `d_out`=0, and no `done` is issued for the cancelled transaction.
  - In IDLE, `abort` blocks acceptance in that same cycle. `in_ready` is forced to 0 while `abort`=1.
- `in_code` values are all legal. No X handling is required beyond reset.

## Timing
- Reset values (asynchronous assertion): state IDLE, `d_out`=8'h00, `busy`=0, `done`=0, `err`=0, counters 0, latched code 0. `in_ready`=1 after deassertion; it is 0 while `rst_n`=0.
- Latency: acceptance at edge k puts `d_out` valid from edge k through edge k+HOLD (HOLD cycles).
  - `done` is high during the cycle after edge k+HOLD-1.
  - `in_ready` returns at edge k+HOLD+GAP.
- Throughput: one transaction per HOLD+GAP+1 cycles, because the IDLE acceptance cycle is not overlapped.
- `d_out`, `busy`, and `err` are registered. `done` and `in_ready` are decoded from state and have no input-to-output combinational path, except the `abort` gating of `in_ready`.
- Reset during DRIVE or GAP immediately clears all outputs. The transaction is lost and no `done` is issued.

## Configuration
- Macro `P_D_LOOPBACK_EN`, when defined:
  - An internal 8-to-3 priority encoder (highest set bit wins, zero→000) re-encodes `d_out` every DRIVE cycle.
  - If the latched `in_none`=0 and the re-encoded value differs from the latched code, `err` sets at the next edge.
  - `err` is sticky. It clears only on reset or `abort`.
- When `P_D_LOOPBACK_EN` is undefined, `err` is tied to 0 and no encoder logic is present.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `d_out`=00, `busy`=0, `done`=0, `err`=0, `in_ready`=0. Release → `in_ready`=1.
- HOLD=4, GAP=1, accept code 5 → `d_out`=8'h20 for exactly 4 cycles, `done` on the 4th, 1 GAP cycle, then `in_ready`=1. Repeat this for codes 0..7 (8'h01..8'h80).
- Accept code 3 with `in_none`=1 → `d_out`=00 for 4 cycles, `busy`=1, `done` pulses once.
- GAP=0, `in_valid` held high with codes 1 then 6 → 8'h02×4 cycles, 1 cycle 00 (IDLE accept), then 8'h40×4 cycles.
- `abort` on the 2nd DRIVE cycle of code 7 → `d_out`=00 at the next edge, no `done`, `in_ready`=1 the cycle after `abort` drops. Reset asserted mid-DRIVE → outputs cleared asynchronously.
- With `P_D_LOOPBACK_EN`, sweep codes 0..7 → `err` stays 0. Force a `d_out` bit during DRIVE → `err`=1 stays high until `abort`.
